// File: rtl/match_log_pkg.sv
// Shared constants and helpers for the match event logger and its FIFO.
package match_log_pkg;

  localparam int TS_W_DEFAULT  = 16;
  localparam int DEPTH_DEFAULT = 4;
  localparam int CNT_W_DEFAULT = 16;
  localparam int ENTRY_W       = TS_W_DEFAULT + 1;

  // Stored entry is {ovf, ts}.
  function automatic int entry_width(input int ts_w);
    return ts_w + 1;
  endfunction

  // Counters up to 32 bits wide are zero-extended into this helper and truncated back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO; head entry is decoded directly from storage and read pointer.
module sync_fifo_sa
  import match_log_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells a wrapped (full) FIFO from an empty one.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    dout  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next pointers and storage; a push while full is accepted only alongside a pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1'b1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end else begin
      mem_d = mem_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps every 1101-detector match into a show-ahead FIFO, with saturating
// match/drop counters and an overflow marker on the first entry after a drop.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             match_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [TS_W-1:0]  ev_ts,
  output logic             ev_ovf,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             drop_flag
);

  localparam int                EW      = entry_width(TS_W);
  localparam logic [31:0]       CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] match_count_q, match_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             drop_flag_q, drop_flag_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             fifo_full, fifo_empty;
  logic             pop, push, drop;
  logic [EW-1:0]    fifo_din, fifo_dout;

  // Flow control depends only on registered FIFO state plus the inputs.
  always_comb begin
    pop      = !fifo_empty && ev_ready;
    push     = match_in && (!fifo_full || pop);
    drop     = match_in && fifo_full && !pop;
    fifo_din = {ovf_pend_q && !clr, ts_q};
  end

  sync_fifo_sa #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state for timestamp, counters and overflow tracking; clr takes priority.
  always_comb begin
    ts_d = ts_q + TS_W'(1'b1);
    if (clr) begin
      match_count_d = '0;
      drop_count_d  = '0;
      drop_flag_d   = 1'b0;
      ovf_pend_d    = 1'b0;
    end else begin
      match_count_d = match_in ? CNT_W'(sat_inc(32'(match_count_q), CNT_MAX)) : match_count_q;
      drop_count_d  = drop ? CNT_W'(sat_inc(32'(drop_count_q), CNT_MAX)) : drop_count_q;
      drop_flag_d   = drop_flag_q || drop;
      if (drop) begin
        ovf_pend_d = 1'b1;
      end else if (push) begin
        ovf_pend_d = 1'b0;
      end else begin
        ovf_pend_d = ovf_pend_q;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q          <= '0;
      match_count_q <= '0;
      drop_count_q  <= '0;
      drop_flag_q   <= 1'b0;
      ovf_pend_q    <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      match_count_q <= match_count_d;
      drop_count_q  <= drop_count_d;
      drop_flag_q   <= drop_flag_d;
      ovf_pend_q    <= ovf_pend_d;
    end
  end

  // Outputs decoded from registers only.
  always_comb begin
    ev_valid    = !fifo_empty;
    ev_ts       = fifo_dout[TS_W-1:0];
    ev_ovf      = fifo_dout[TS_W];
    match_count = match_count_q;
    drop_count  = drop_count_q;
    drop_flag   = drop_flag_q;
  end

endmodule

// File: tb/tb_match_event_logger.sv
// Directed, table-driven bench for match_event_logger (default and narrow-width instances).
module tb_match_event_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // Default-parameter instance; match_in can come from the bench or from a 1101 detector model.
  logic        clr_a = 1'b0, match_r = 1'b0, ready_a = 1'b0, det_en = 1'b0, din = 1'b0;
  logic        match_a, det_y;
  logic        ev_valid_a, ev_ovf_a, df_a;
  logic [15:0] ev_ts_a, mc_a, dc_a;

  // Narrow instance: TS_W=4 for wrap, CNT_W=3 for saturation.
  logic        clr_s = 1'b0, match_s = 1'b0, ready_s = 1'b0;
  logic        ev_valid_s, ev_ovf_s, df_s;
  logic [3:0]  ev_ts_s;
  logic [2:0]  mc_s, dc_s;

  assign match_a = det_en ? det_y : match_r;

  match_event_logger u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .match_in(match_a),
    .ev_valid(ev_valid_a), .ev_ready(ready_a), .ev_ts(ev_ts_a), .ev_ovf(ev_ovf_a),
    .match_count(mc_a), .drop_count(dc_a), .drop_flag(df_a)
  );

  match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .match_in(match_s),
    .ev_valid(ev_valid_s), .ev_ready(ready_s), .ev_ts(ev_ts_s), .ev_ovf(ev_ovf_s),
    .match_count(mc_s), .drop_count(dc_s), .drop_flag(df_s)
  );

  // Reference 1101 Mealy detector with overlap.
  typedef enum logic [1:0] {D0, D1, D11, D110} det_t;
  det_t det_st = D0, det_nx;
  always_comb begin
    det_y = (det_st == D110) && din;
    case (det_st)
      D0:      det_nx = din ? D1 : D0;
      D1:      det_nx = din ? D11 : D0;
      D11:     det_nx = din ? D11 : D110;
      D110:    det_nx = din ? D1 : D0;
      default: det_nx = D0;
    endcase
  end
  always @(posedge clk) begin
    if (!rst_n) det_st <= D0;
    else        det_st <= det_nx;
  end

  int n_checks = 0;
  int n_errors = 0;
  int ts_m     = 0;

  typedef struct {
    int   ts;
    logic m, r, c;
    logic v;
    int   ets;
    logic eovf;
    int   mc, dc;
    logic df;
  } vec_t;
  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    if (!rst_n) ts_m = 0;
    else        ts_m = ts_m + 1;
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (ts_m=%0d)", nm, act, exp, ts_m);
    end
  endtask

  task automatic wait_ts(input int t, input int modulus);
    int guard = 0;
    while (((ts_m % modulus) != t) && (guard < 300)) begin
      tick();
      guard++;
    end
    if (guard >= 300) begin
      n_errors++;
      $display("FAIL wait_ts: timestamp %0d never reached, stuck at %0d", t, ts_m);
    end
  endtask

  initial begin
    logic [6:0] bits;
    int         t0;

    // ts, m, r, c, valid, ts, ovf, match_count, drop_count, drop_flag
    vecs.push_back('{5,  1'b1, 1'b0, 1'b0, 1'b1, 5,  1'b0, 1,  0, 1'b0});
    vecs.push_back('{7,  1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1,  0, 1'b0});
    vecs.push_back('{8,  1'b0, 1'b0, 1'b1, 1'b0, 0,  1'b0, 0,  0, 1'b0});
    vecs.push_back('{10, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 1,  0, 1'b0});
    vecs.push_back('{13, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 2,  0, 1'b0});
    vecs.push_back('{16, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 3,  0, 1'b0});
    vecs.push_back('{19, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 4,  0, 1'b0});
    vecs.push_back('{22, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 5,  1, 1'b1});
    vecs.push_back('{25, 1'b1, 1'b0, 1'b0, 1'b1, 10, 1'b0, 6,  2, 1'b1});
    vecs.push_back('{30, 1'b0, 1'b1, 1'b0, 1'b1, 13, 1'b0, 6,  2, 1'b1});
    vecs.push_back('{31, 1'b0, 1'b1, 1'b0, 1'b1, 16, 1'b0, 6,  2, 1'b1});
    vecs.push_back('{32, 1'b0, 1'b1, 1'b0, 1'b1, 19, 1'b0, 6,  2, 1'b1});
    vecs.push_back('{33, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 6,  2, 1'b1});
    vecs.push_back('{40, 1'b1, 1'b1, 1'b0, 1'b1, 40, 1'b1, 7,  2, 1'b1});
    vecs.push_back('{41, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 7,  2, 1'b1});
    vecs.push_back('{50, 1'b1, 1'b0, 1'b0, 1'b1, 50, 1'b0, 8,  2, 1'b1});
    vecs.push_back('{51, 1'b1, 1'b0, 1'b0, 1'b1, 50, 1'b0, 9,  2, 1'b1});
    vecs.push_back('{52, 1'b1, 1'b0, 1'b0, 1'b1, 50, 1'b0, 10, 2, 1'b1});
    vecs.push_back('{53, 1'b1, 1'b0, 1'b0, 1'b1, 50, 1'b0, 11, 2, 1'b1});
    vecs.push_back('{54, 1'b1, 1'b1, 1'b0, 1'b1, 51, 1'b0, 12, 2, 1'b1});
    vecs.push_back('{55, 1'b1, 1'b0, 1'b0, 1'b1, 51, 1'b0, 13, 3, 1'b1});
    vecs.push_back('{60, 1'b0, 1'b1, 1'b0, 1'b1, 52, 1'b0, 13, 3, 1'b1});
    vecs.push_back('{61, 1'b0, 1'b1, 1'b0, 1'b1, 53, 1'b0, 13, 3, 1'b1});
    vecs.push_back('{62, 1'b0, 1'b1, 1'b0, 1'b1, 54, 1'b0, 13, 3, 1'b1});
    vecs.push_back('{63, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 13, 3, 1'b1});
    vecs.push_back('{70, 1'b1, 1'b0, 1'b1, 1'b1, 70, 1'b0, 0,  0, 1'b0});
    vecs.push_back('{71, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 0,  0, 1'b0});
    vecs.push_back('{75, 1'b1, 1'b0, 1'b0, 1'b1, 75, 1'b0, 1,  0, 1'b0});
    vecs.push_back('{76, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1'b0, 1,  0, 1'b0});

    tick();
    tick();
    check("rst_valid", 32'(ev_valid_a), 32'd0);
    check("rst_ts",    32'(ev_ts_a),    32'd0);
    check("rst_ovf",   32'(ev_ovf_a),   32'd0);
    check("rst_mc",    32'(mc_a),       32'd0);
    check("rst_dc",    32'(dc_a),       32'd0);
    check("rst_df",    32'(df_a),       32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wait_ts(vecs[i].ts, 1 << 30);
      match_r = vecs[i].m;
      ready_a = vecs[i].r;
      clr_a   = vecs[i].c;
      tick();
      match_r = 1'b0;
      ready_a = 1'b0;
      clr_a   = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(ev_valid_a), 32'(vecs[i].v));
      if (vecs[i].v) begin
        check($sformatf("vec%0d_ts", i),  32'(ev_ts_a),  32'(vecs[i].ets));
        check($sformatf("vec%0d_ovf", i), 32'(ev_ovf_a), 32'(vecs[i].eovf));
      end
      check($sformatf("vec%0d_mc", i), 32'(mc_a), 32'(vecs[i].mc));
      check($sformatf("vec%0d_dc", i), 32'(dc_a), 32'(vecs[i].dc));
      check($sformatf("vec%0d_df", i), 32'(df_a), 32'(vecs[i].df));
    end

    // Timestamp wrap on the 4-bit instance: entries 14 then 1.
    wait_ts(14, 16);
    match_s = 1'b1; tick(); match_s = 1'b0;
    wait_ts(1, 16);
    match_s = 1'b1; tick(); match_s = 1'b0;
    check("wrap_valid", 32'(ev_valid_s), 32'd1);
    check("wrap_first", 32'(ev_ts_s),    32'd14);
    ready_s = 1'b1; tick(); ready_s = 1'b0;
    check("wrap_second", 32'(ev_ts_s),   32'd1);
    ready_s = 1'b1; tick(); ready_s = 1'b0;
    check("wrap_empty", 32'(ev_valid_s), 32'd0);
    check("wrap_mc",    32'(mc_s),       32'd2);

    // Saturation with back-to-back matches on the 3-bit counters.
    clr_s = 1'b1; tick(); clr_s = 1'b0;
    check("sat_clr_mc", 32'(mc_s), 32'd0);
    match_s = 1'b1;
    ready_s = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 2) check("sat_mc3", 32'(mc_s), 32'd3);
    end
    match_s = 1'b0;
    check("sat_mc", 32'(mc_s), 32'd7);
    check("sat_dc", 32'(dc_s), 32'd0);
    check("sat_df", 32'(df_s), 32'd0);
    tick();
    ready_s = 1'b0;
    check("sat_drained", 32'(ev_valid_s), 32'd0);

    // Detector-driven stream 1101101: two matches, 3 cycles apart.
    det_en = 1'b1;
    bits   = 7'b1101101;
    t0     = ts_m;
    for (int k = 0; k < 7; k++) begin
      din = bits[6-k];
      tick();
    end
    din = 1'b0;
    tick();
    tick();
    check("det_valid", 32'(ev_valid_a), 32'd1);
    check("det_ts0",   32'(ev_ts_a),    32'(t0 + 3));
    check("det_mc",    32'(mc_a),       32'd3);
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    check("det_ts1",   32'(ev_ts_a),    32'(t0 + 6));
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    check("det_two_only", 32'(ev_valid_a), 32'd0);

    // Reset mid-stream discards the FIFO.
    for (int k = 0; k < 4; k++) begin
      din = bits[6-k];
      tick();
    end
    check("mid_pre_valid", 32'(ev_valid_a), 32'd1);
    din   = 1'b1;
    rst_n = 1'b0;
    tick();
    check("mid_valid", 32'(ev_valid_a), 32'd0);
    check("mid_ts",    32'(ev_ts_a),    32'd0);
    check("mid_mc",    32'(mc_a),       32'd0);
    check("mid_df",    32'(df_a),       32'd0);
    rst_n  = 1'b1;
    din    = 1'b0;
    det_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
